// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states and line constants for the receive and transmit paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: host-side byte handshake and status of the UART receiver (UART_RX_PARITY_EN adds rx_parity_err)
interface uart_receiver_if;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif
  modport master (
    input rx_ack,
`ifdef UART_RX_PARITY_EN
    output rx_parity_err,
`endif
    output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
  );
  modport slave (
    output rx_ack,
`ifdef UART_RX_PARITY_EN
    input rx_parity_err,
`endif
    input rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous pin, both flops reset to the idle-high level
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // shift the pin through two flops; reset to 1 so an idle line never looks like a start bit
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2_q, s1_q} <= 2'b11;
    else     {s2_q, s1_q} <= {s1_q, d};
  assign q = s2_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receive path with valid/ack holding register (UART_RX_PARITY_EN adds even parity)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic            CLK_BPS,
  input  logic            reset,
  input  logic            uart_txd_in,
  uart_receiver_if.master rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;
  localparam logic [2:0] S_BREAK = BREAK;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic          line;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          stop_hit, par_bad, good, load;

  uart_rx_sync u_sync (
    .clk (CLK_BPS),
    .rst (reset),
    .d   (uart_txd_in),
    .q   (line)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_bad = ^{shift_q, par_q};
  assign perr_d  = stop_hit & line & par_bad;
  assign rx.rx_parity_err = perr_q;
`else
  assign par_bad = 1'b0;
`endif

  // frame FSM: start qualification at mid-bit, then one sample per bit period
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = line ? S_IDLE : S_START;
      end
      S_START:
        if (cnt_q == CNT_MID) begin
          state_d = line ? S_IDLE : S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      S_DATA:
        if (cnt_q == CNT_END) begin
          shift_d[idx_q] = line;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          state_d        = (idx_q == IDX_LAST) ? S_AFTER_DATA : S_DATA;
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (cnt_q == CNT_END) begin
          par_d   = line;
          cnt_d   = '0;
          state_d = S_STOP;
        end
`endif
      S_STOP:
        if (cnt_q == CNT_END) begin
          stop_hit = 1'b1;
          cnt_d    = '0;
          state_d  = line ? S_IDLE : S_BREAK;
        end
      S_BREAK: begin
        cnt_d   = '0;
        state_d = (line == UART_LINE_IDLE) ? S_IDLE : S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a good frame loads the holding register unless an unconsumed byte blocks it
  always_comb begin
    good    = stop_hit & line & ~par_bad;
    load    = good & (~valid_q | rx.rx_ack);
    data_d  = load ? shift_q : data_q;
    valid_d = load | (valid_q & ~rx.rx_ack);
    ovr_d   = good & valid_q & ~rx.rx_ack;
    ferr_d  = stop_hit & ~line;
  end

  // state and output registers; reset aborts any frame in progress
  always_ff @(posedge CLK_BPS or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_busy      = state_q != S_IDLE;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame tests for uart_receiver at OVERSAMPLE=16 (UART_RX_PARITY_EN enables parity cases)
module tb_uart_receiver;
  localparam int OS = 16;
  logic CLK_BPS = 1'b0;
  logic reset = 1'b1;
  logic uart_txd_in = 1'b1;
  int checks = 0;
  int failures = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int f0, o0;

  uart_receiver_if rx_if ();

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .CLK_BPS     (CLK_BPS),
    .reset       (reset),
    .uart_txd_in (uart_txd_in),
    .rx          (rx_if)
  );

  always #5 CLK_BPS = ~CLK_BPS;

  always @(negedge CLK_BPS) begin
    if (rx_if.rx_frame_err) ferr_n++;
    if (rx_if.rx_overrun) ovr_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_BPS);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b);
    uart_txd_in = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      tick(OS);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_head(b);
    uart_txd_in = 1'b1;
    tick(OS);
  endtask

  task automatic ack();
    rx_if.rx_ack = 1'b1;
    tick(1);
    rx_if.rx_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a5;
    rx_if.rx_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_data", rx_if.rx_data, 8'h00);
    check("rst_valid", rx_if.rx_valid, 1'b0);
    check("rst_busy", rx_if.rx_busy, 1'b0);
    check("rst_ferr", rx_if.rx_frame_err, 1'b0);
    check("rst_ovr", rx_if.rx_overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", rx_if.rx_parity_err, 1'b0);
`endif
    // 0xA5 with exact edge checks
    a5 = 8'hA5;
    uart_txd_in = 1'b0;
    tick(2);
    check("a5_busy_e1", rx_if.rx_busy, 1'b0);
    tick(1);
    check("a5_busy_e2", rx_if.rx_busy, 1'b1);
    tick(OS - 3);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = a5[i];
      tick(OS);
    end
    uart_txd_in = 1'b1;
    tick(10);
    check("a5_valid_e153", rx_if.rx_valid, 1'b0);
    tick(1);
    check("a5_valid_e154", rx_if.rx_valid, 1'b1);
    check("a5_data", rx_if.rx_data, 8'hA5);
    check("a5_busy_e154", rx_if.rx_busy, 1'b0);
    tick(5);
    ack();
    check("a5_ack_clear", rx_if.rx_valid, 1'b0);
    check("a5_data_kept", rx_if.rx_data, 8'hA5);
    // glitch: 4 low cycles
    f0 = ferr_n; o0 = ovr_n;
    uart_txd_in = 1'b0;
    tick(4);
    uart_txd_in = 1'b1;
    tick(2);
    check("glitch_busy_e5", rx_if.rx_busy, 1'b1);
    tick(5);
    check("glitch_busy_e10", rx_if.rx_busy, 1'b0);
    tick(20);
    check("glitch_valid", rx_if.rx_valid, 1'b0);
    check("glitch_ferr", ferr_n - f0, 0);
    check("glitch_ovr", ovr_n - o0, 0);
    // 0x3C with low stop bit, line held low
    f0 = ferr_n;
    send_head(8'h3C);
    uart_txd_in = 1'b0;
    tick(OS);
    tick(40);
    check("brk_busy", rx_if.rx_busy, 1'b1);
    check("brk_ferr_cnt", ferr_n - f0, 1);
    check("brk_valid", rx_if.rx_valid, 1'b0);
    check("brk_data", rx_if.rx_data, 8'hA5);
    uart_txd_in = 1'b1;
    tick(4);
    check("brk_release", rx_if.rx_busy, 1'b0);
    send_frame(8'h81);
    check("post_brk_data", rx_if.rx_data, 8'h81);
    check("post_brk_valid", rx_if.rx_valid, 1'b1);
    check("post_brk_ferr", ferr_n - f0, 1);
    ack();
    // overrun: back-to-back without ack
    o0 = ovr_n;
    send_frame(8'h11);
    send_head(8'h22);
    uart_txd_in = 1'b1;
    tick(11);
    check("ovr_pulse", rx_if.rx_overrun, 1'b1);
    tick(1);
    check("ovr_pulse_end", rx_if.rx_overrun, 1'b0);
    tick(4);
    check("ovr_data", rx_if.rx_data, 8'h11);
    check("ovr_valid", rx_if.rx_valid, 1'b1);
    check("ovr_cnt", ovr_n - o0, 1);
    ack();
    check("ovr_ack", rx_if.rx_valid, 1'b0);
    // ack coincident with second stop sample
    o0 = ovr_n;
    send_frame(8'h11);
    send_head(8'h22);
    uart_txd_in = 1'b1;
    tick(10);
    rx_if.rx_ack = 1'b1;
    tick(1);
    rx_if.rx_ack = 1'b0;
    check("ackst_data", rx_if.rx_data, 8'h22);
    check("ackst_valid", rx_if.rx_valid, 1'b1);
    check("ackst_ovr", rx_if.rx_overrun, 1'b0);
    tick(5);
    check("ackst_ovr_cnt", ovr_n - o0, 0);
    // reset during data bit 4 of 0xFF
    f0 = ferr_n;
    uart_txd_in = 1'b0;
    tick(OS);
    uart_txd_in = 1'b1;
    tick(4 * OS + OS / 2);
    check("pre_rst_busy", rx_if.rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_data", rx_if.rx_data, 8'h00);
    check("mid_rst_valid", rx_if.rx_valid, 1'b0);
    check("mid_rst_busy", rx_if.rx_busy, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(5);
    send_frame(8'h5A);
    check("post_rst_data", rx_if.rx_data, 8'h5A);
    check("post_rst_valid", rx_if.rx_valid, 1'b1);
    check("post_rst_ferr", ferr_n - f0, 0);
    ack();
`ifdef UART_RX_PARITY_EN
    send_head(8'h07);
    uart_txd_in = 1'b1;
    tick(OS);
    uart_txd_in = 1'b1;
    tick(10);
    check("par_ok_e169", rx_if.rx_valid, 1'b0);
    tick(1);
    check("par_ok_e170", rx_if.rx_valid, 1'b1);
    check("par_ok_data", rx_if.rx_data, 8'h07);
    check("par_ok_perr", rx_if.rx_parity_err, 1'b0);
    tick(5);
    ack();
    send_head(8'h07);
    uart_txd_in = 1'b0;
    tick(OS);
    uart_txd_in = 1'b1;
    tick(11);
    check("par_bad_perr", rx_if.rx_parity_err, 1'b1);
    check("par_bad_valid", rx_if.rx_valid, 1'b0);
    tick(1);
    check("par_bad_perr_end", rx_if.rx_parity_err, 1'b0);
    tick(4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
